program_memory_loader: RTL and testbench

//  Program memory for the SimpleCPU: 64 x 8 instruction/data store, read by the control unit.
//  The control unit reads with address = AR, READ = its READ strobe, and takes data onto mem_bus.
//  A byte-stream loader fills the memory after reset over a valid/ready handshake.
//  cpu_hold keeps the control unit stalled until loading completes.

---
 rtl/program_memory_loader.sv | 121 ++++++++++++
 tb/tb_program_memory_loader.sv | 190 +++++++++++++++++++
 2 files changed

// File: rtl/program_memory_loader.sv
// SimpleCPU program memory: 64 x 8 store filled by a valid/ready byte loader after reset,
// then read combinationally by the control unit while cpu_hold is released.
module program_memory_loader #(
  parameter int    ADDR_W    = 6,
  parameter int    DATA_W    = 8,
  parameter string INIT_FILE = ""
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [ADDR_W-1:0] address,
  input  logic              READ,
  output logic [DATA_W-1:0] data,
  input  logic              ld_valid,
  output logic              ld_ready,
  input  logic [DATA_W-1:0] ld_data,
  input  logic              ld_last,
  input  logic              ld_start,
  output logic              cpu_hold,
  output logic              load_done,
  output logic [ADDR_W:0]   load_count,
  output logic [DATA_W-1:0] checksum,
  output logic              len_err
);

  localparam int DEPTH = 2 ** ADDR_W;

  typedef enum logic {
    LOAD = 1'b0,
    RUN  = 1'b1
  } state_t;

  state_t              state_q, state_d;
  logic [ADDR_W-1:0]   wptr_q, wptr_d;
  logic [ADDR_W:0]     count_q, count_d;
  logic [DATA_W-1:0]   sum_q, sum_d;
  logic                len_err_q, len_err_d;
  logic                done_q, done_d;
  logic                hold_q, hold_d;
  logic                accept;
  logic                last_loc;
  logic [DATA_W-1:0]   mem_q [DEPTH];

  function automatic logic [DATA_W-1:0] add_wrap(input logic [DATA_W-1:0] a,
                                                 input logic [DATA_W-1:0] b);
    return a + b;
  endfunction

  assign ld_ready = (state_q == LOAD);
  assign accept   = ld_valid && ld_ready;
  assign last_loc = (wptr_q == ADDR_W'(DEPTH - 1));

  always_comb begin
    state_d   = state_q;
    wptr_d    = wptr_q;
    count_d   = count_q;
    sum_d     = sum_q;
    len_err_d = len_err_q;
    done_d    = 1'b0;
    hold_d    = hold_q;
    unique case (state_q)
      LOAD: begin
        if (accept) begin
          wptr_d  = wptr_q + ADDR_W'(1);
          count_d = count_q + (ADDR_W + 1)'(1);
          sum_d   = add_wrap(sum_q, ld_data);
          // The final location ends the image even without ld_last; flag the short marker.
          if (ld_last || last_loc) begin
            state_d = RUN;
            hold_d  = 1'b0;
            done_d  = 1'b1;
            if (!ld_last) len_err_d = 1'b1;
          end
        end
      end
      RUN: begin
        if (ld_start) begin
          state_d   = LOAD;
          hold_d    = 1'b1;
          wptr_d    = '0;
          count_d   = '0;
          sum_d     = '0;
          len_err_d = 1'b0;
        end
      end
      default: state_d = LOAD;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q   <= LOAD;
      wptr_q    <= '0;
      count_q   <= '0;
      sum_q     <= '0;
      len_err_q <= 1'b0;
      done_q    <= 1'b0;
      hold_q    <= 1'b1;
    end else begin
      state_q   <= state_d;
      wptr_q    <= wptr_d;
      count_q   <= count_d;
      sum_q     <= sum_d;
      len_err_q <= len_err_d;
      done_q    <= done_d;
      hold_q    <= hold_d;
    end
  end

  // Storage is not reset so an interrupted load leaves earlier bytes intact.
  always_ff @(posedge clk) begin
    if (accept) mem_q[wptr_q] <= ld_data;
  end

  assign data       = (state_q == RUN && READ) ? mem_q[address] : 'z;
  assign cpu_hold   = hold_q;
  assign load_done  = done_q;
  assign load_count = count_q;
  assign checksum   = sum_q;
  assign len_err    = len_err_q;

endmodule

// File: tb/tb_program_memory_loader.sv
// Directed bench for program_memory_loader: loads, reads, boundary length, reload and reset abort.
module tb_program_memory_loader;
  localparam int ADDR_W = 6;
  localparam int DATA_W = 8;

  logic              clk = 1'b0;
  logic              reset;
  logic [ADDR_W-1:0] address;
  logic              READ;
  tri1  [DATA_W-1:0] data;
  logic              ld_valid;
  logic              ld_ready;
  logic [DATA_W-1:0] ld_data;
  logic              ld_last;
  logic              ld_start;
  logic              cpu_hold;
  logic              load_done;
  logic [ADDR_W:0]   load_count;
  logic [DATA_W-1:0] checksum;
  logic              len_err;

  int n_checks = 0;
  int n_errors = 0;
  int done_cnt = 0;

  program_memory_loader #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .INIT_FILE("")) dut (
    .clk(clk), .reset(reset), .address(address), .READ(READ), .data(data),
    .ld_valid(ld_valid), .ld_ready(ld_ready), .ld_data(ld_data), .ld_last(ld_last),
    .ld_start(ld_start), .cpu_hold(cpu_hold), .load_done(load_done),
    .load_count(load_count), .checksum(checksum), .len_err(len_err)
  );

  always #5 clk = ~clk;

  always @(negedge clk) if (load_done === 1'b1) done_cnt++;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // Presents one beat; returns #1 after the edge with ld_valid still high.
  task automatic beat(input logic [DATA_W-1:0] d, input logic last);
    ld_valid = 1'b1;
    ld_data  = d;
    ld_last  = last;
    @(posedge clk);
    #1;
  endtask

  task automatic rd(input string tag, input logic [ADDR_W-1:0] a, input logic [DATA_W-1:0] exp);
    address = a;
    READ    = 1'b1;
    #1;
    check(tag, 32'(data), 32'(exp));
    READ = 1'b0;
    #1;
  endtask

  task automatic pulse_start();
    ld_start = 1'b1;
    @(posedge clk);
    #1;
    ld_start = 1'b0;
  endtask

  initial begin
    int i;
    int guard;
    logic v;
    reset = 1'b0; address = '0; READ = 1'b0; ld_valid = 1'b0;
    ld_data = '0; ld_last = 1'b0; ld_start = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    check("rst_hold", 32'(cpu_hold), 32'd1);
    check("rst_done", 32'(load_done), 32'd0);
    check("rst_count", 32'(load_count), 32'd0);
    check("rst_sum", 32'(checksum), 32'd0);
    check("rst_lenerr", 32'(len_err), 32'd0);
    check("rst_ready", 32'(ld_ready), 32'd1);
    check("rst_data_z", 32'(data), 32'hFF);
    reset = 1'b1;
    @(posedge clk); #1;

    // Test 1: three-byte image, valid held high
    beat(8'h05, 1'b0);
    beat(8'h47, 1'b0);
    check("t1_hold_mid", 32'(cpu_hold), 32'd1);
    beat(8'h81, 1'b1);
    ld_valid = 1'b0; ld_last = 1'b0;
    @(negedge clk);
    check("t1_done", 32'(load_done), 32'd1);
    check("t1_hold", 32'(cpu_hold), 32'd0);
    check("t1_ready", 32'(ld_ready), 32'd0);
    check("t1_count", 32'(load_count), 32'd3);
    check("t1_sum", 32'(checksum), 32'hCD);
    check("t1_lenerr", 32'(len_err), 32'd0);
    @(negedge clk);
    check("t1_done_off", 32'(load_done), 32'd0);
    check("t1_done_cnt", 32'(done_cnt), 32'd1);

    // Test 2: reads in RUN
    rd("t2_rd0", 6'd0, 8'h05);
    rd("t2_rd1", 6'd1, 8'h47);
    rd("t2_rd2", 6'd2, 8'h81);
    address = 6'd1; READ = 1'b0; #1;
    check("t2_read_off_z", 32'(data), 32'hFF);

    // Test 3: full-depth image without ld_last
    @(negedge clk);
    pulse_start();
    check("t3_ready", 32'(ld_ready), 32'd1);
    for (int k = 0; k < 64; k++) begin
      beat(8'(k), 1'b0);
      if (k == 62) check("t3_hold_63", 32'(cpu_hold), 32'd1);
    end
    ld_valid = 1'b0;
    @(negedge clk);
    check("t3_count", 32'(load_count), 32'd64);
    check("t3_sum", 32'(checksum), 32'hE0);
    check("t3_lenerr", 32'(len_err), 32'd1);
    check("t3_hold", 32'(cpu_hold), 32'd0);
    @(negedge clk);
    check("t3_ready_after", 32'(ld_ready), 32'd0);
    rd("t3_rd9", 6'd9, 8'h09);
    rd("t3_rd63", 6'd63, 8'h3F);

    // Test 4: 10-byte image with random gaps in ld_valid
    pulse_start();
    check("t4_lenerr_clr", 32'(len_err), 32'd0);
    i = 0; guard = 0;
    while (i < 10 && guard < 400) begin
      v = 1'($urandom_range(0, 1));
      ld_valid = v;
      ld_data  = 8'(8'hA0 + i);
      ld_last  = (i == 9);
      @(posedge clk); #1;
      if (v) i++;
      guard++;
    end
    ld_valid = 1'b0; ld_last = 1'b0;
    check("t4_beats_sent", 32'(i), 32'd10);
    @(negedge clk);
    check("t4_count", 32'(load_count), 32'd10);
    check("t4_sum", 32'(checksum), 32'h6D);
    check("t4_lenerr", 32'(len_err), 32'd0);
    for (int k = 0; k < 10; k++) rd("t4_rd", 6'(k), 8'(8'hA0 + k));
    rd("t4_rd10_kept", 6'd10, 8'h0A);

    // Test 5: reload request with a coincident beat
    @(negedge clk);
    check("t5_ready_pre", 32'(ld_ready), 32'd0);
    ld_valid = 1'b1; ld_data = 8'h55; ld_last = 1'b1;
    pulse_start();
    ld_valid = 1'b0; ld_last = 1'b0;
    @(negedge clk);
    check("t5_hold", 32'(cpu_hold), 32'd1);
    check("t5_count", 32'(load_count), 32'd0);
    check("t5_sum", 32'(checksum), 32'd0);
    check("t5_ready", 32'(ld_ready), 32'd1);

    // Test 6: reset after two bytes, then a one-byte reload
    beat(8'h11, 1'b0);
    beat(8'h22, 1'b0);
    ld_valid = 1'b0;
    check("t6_count_pre", 32'(load_count), 32'd2);
    reset = 1'b0;
    #1;
    check("t6_rst_count", 32'(load_count), 32'd0);
    check("t6_rst_hold", 32'(cpu_hold), 32'd1);
    @(negedge clk);
    reset = 1'b1;
    @(posedge clk); #1;
    beat(8'hAA, 1'b1);
    ld_valid = 1'b0; ld_last = 1'b0;
    @(negedge clk);
    check("t6_count", 32'(load_count), 32'd1);
    check("t6_sum", 32'(checksum), 32'hAA);
    check("t6_hold", 32'(cpu_hold), 32'd0);
    rd("t6_rd0", 6'd0, 8'hAA);
    rd("t6_rd1_kept", 6'd1, 8'h22);
    rd("t6_rd2_kept", 6'd2, 8'hA2);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end
endmodule
